mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer for the 8-column gated MAC array. Per tile it:
- pulls PR weight vectors from the L0 FIFO and issues them as load instructions;
- waits for the weights to settle in every column;
- streams N activation vectors as execute instructions;
- drains exactly N psum vectors from the output FIFO.
Sits between the top-level core FSM (start/done) and the L0 FIFO / MAC array / OFIFO.

Parameters:
COL, 8, number of MAC columns (load propagation depth)
PR, 8, weight vectors loaded per tile
LEN_BW, 6, width of the activation-count field
WDT_BW, 10, watchdog counter width (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  begin one tile; sampled only in IDLE
n_act  input  LEN_BW  number of activation vectors for this tile; latched at start
l0_empty  input  1  L0 FIFO empty
l0_rd  output  1  L0 FIFO pop, same cycle as the issued instruction
inst  output  2  to array: [1] execute, [0] load; 00 = idle
ld_done  input  1  array reports all columns loaded
ofifo_valid  input  1  OFIFO holds at least one psum vector
ofifo_rd  output  1  OFIFO pop
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at tile completion
out_cnt  output  LEN_BW  psum vectors popped in the current or last tile
err  output  1  watchdog abort flag (tied 0 without the optional feature)

Behaviour:
Reset and clocking
- Clock is clk; reset is synchronous and active-high.
- Reset forces state IDLE and clears all counters and latches.
- Reset values: inst=00, l0_rd=0, ofifo_rd=0, busy=0, done=0, out_cnt=0, err=0.
- Reset mid-operation aborts immediately; no done pulse is produced.

Output timing
- inst, l0_rd and ofifo_rd are combinational from state, counters, l0_empty and ofifo_valid.
- inst[1:0] and l0_rd always assert together (one instruction per popped L0 entry).
- All other outputs are registered.

States
- IDLE: outputs idle. If start=1, latch n_act, clear out_cnt and counters, go to LOAD. start in any other state is ignored.
- LOAD: each cycle with l0_empty=0, assert l0_rd=1, inst=01 and increment k. When l0_empty=1, stall with inst=00 and k held. After the PR-th issue (k reaches PR), go to LOAD_WAIT.
- LOAD_WAIT: inst=00. Count w from 0. Leave when w >= COL and ld_done=1; a minimum of COL cycles always elapses.
  - n_act=0: go to DONE.
  - otherwise: go to EXEC.
- EXEC: same stall rule as LOAD, with inst=10. After n_act issues, go to DRAIN. Back-to-back issues are allowed every cycle.
- DRAIN: inst=00 and ofifo_rd = ofifo_valid. Each pop increments out_cnt. When out_cnt reaches the latched n_act, go to DONE. That final pop and the transition occur in the same cycle.
- DONE: done=1 for exactly one cycle, then go to IDLE.

Counter and hold rules
- out_cnt holds its value in IDLE until the next accepted start.
- Counters never wrap: k stops at PR, and the activation count and out_cnt stop at n_act.
- n_act = 2^LEN_BW-1 is legal.

Minimum latency
- With no stalls: start -> done = 1 + PR + COL + n_act + n_act + 1 cycles.
- This assumes ld_done is already high and each OFIFO entry is available when DRAIN reaches it.

Optional Feature:
MAC_SEQ_WDT_EN
- Defined:
  - Adds a WDT_BW-bit watchdog counter, active in LOAD, LOAD_WAIT, EXEC and DRAIN.
  - The counter clears on any l0_rd, ofifo_rd or state change, and increments otherwise.
  - When it reaches all-ones: go to IDLE without a done pulse and set err=1.
  - err is sticky until the next accepted start or reset.
- Undefined: no watchdog logic; err is constant 0; the FSM may wait indefinitely.

Test Plan:
1. Reset mid-EXEC (after 3 of 5 activation issues): next cycle inst=00, busy=0, out_cnt=0. A new start then runs a full tile cleanly.
2. Nominal tile, n_act=4, L0 never empty, ld_done=1, OFIFO valid from DRAIN entry:
   - 8 cycles of inst=01 with l0_rd=1, then 8 idle cycles, then 4 cycles of inst=10;
   - then 4 ofifo_rd pulses and done 1 cycle later;
   - out_cnt=4, start-to-done 26 cycles.
3. L0 empty for 3 cycles after the 2nd load: inst=00 and l0_rd=0 during the gap; total inst=01 count stays 8; done is delayed by 3 cycles.
4. n_act=0: tile goes LOAD -> LOAD_WAIT -> DONE with no inst=10 and no ofifo_rd; done pulses, out_cnt=0.
5. start held high for the whole tile plus 1: exactly one tile runs. A second tile starts only from the start sampled in IDLE after done.
6. (MAC_SEQ_WDT_EN) ld_done held 0 in LOAD_WAIT: after 1023 stalled cycles err=1, busy=0, no done pulse. The next start clears err.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Tile sequencer for the gated MAC array: load, settle, execute, drain.
// Optional watchdog abort enabled by defining MAC_SEQ_WDT_EN.
module mac_seq_ctrl #(
  parameter int COL    = 8,
  parameter int PR     = 8,
  parameter int LEN_BW = 6,
  parameter int WDT_BW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_BW-1:0] n_act,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [1:0]        inst,
  input  logic              ld_done,
  input  logic              ofifo_valid,
  output logic              ofifo_rd,
  output logic              busy,
  output logic              done,
  output logic [LEN_BW-1:0] out_cnt,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LWAIT = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int KW = $clog2(PR + 1);
  localparam int WW = $clog2(COL + 1);

  logic [2:0]        state, state_n;
  logic [KW-1:0]     k;
  logic [WW-1:0]     w;
  logic [LEN_BW-1:0] n_lat;
  logic [LEN_BW-1:0] a_cnt;
  logic              ld_iss, ex_iss;
  logic              wdt_trip;

  assign ld_iss   = (state == S_LOAD) && !l0_empty;
  assign ex_iss   = (state == S_EXEC) && !l0_empty;
  assign l0_rd    = ld_iss || ex_iss;
  assign inst     = {ex_iss, ld_iss};
  assign ofifo_rd = (state == S_DRAIN) && ofifo_valid;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD:  if (ld_iss && k == KW'(PR - 1)) state_n = S_LWAIT;
      S_LWAIT: begin
        // w counts cycles already spent here, so COL is the floor
        if (w >= WW'(COL - 1) && ld_done)
          state_n = (n_lat == '0) ? S_DONE : S_EXEC;
      end
      S_EXEC:  if (ex_iss && a_cnt == n_lat - LEN_BW'(1)) state_n = S_DRAIN;
      S_DRAIN: if (ofifo_rd && out_cnt == n_lat - LEN_BW'(1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (wdt_trip) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      k       <= '0;
      w       <= '0;
      n_lat   <= '0;
      a_cnt   <= '0;
      out_cnt <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state_n == S_DONE);
      if (state == S_IDLE && start) begin
        n_lat   <= n_act;
        k       <= '0;
        w       <= '0;
        a_cnt   <= '0;
        out_cnt <= '0;
      end
      if (ld_iss) k <= k + KW'(1);
      if (ex_iss) a_cnt <= a_cnt + LEN_BW'(1);
      if (state == S_LWAIT && w < WW'(COL - 1)) w <= w + WW'(1);
      if (ofifo_rd) out_cnt <= out_cnt + LEN_BW'(1);
    end
  end

`ifdef MAC_SEQ_WDT_EN
  logic [WDT_BW-1:0] wdt;
  logic              active;

  assign active   = (state != S_IDLE) && (state != S_DONE);
  assign wdt_trip = active && (&wdt);

  always_ff @(posedge clk) begin
    if (reset) begin
      wdt <= '0;
      err <= 1'b0;
    end else begin
      if (!active || l0_rd || ofifo_rd || state_n != state)
        wdt <= '0;
      else
        wdt <= wdt + WDT_BW'(1);
      if (state == S_IDLE && start)
        err <= 1'b0;
      else if (wdt_trip)
        err <= 1'b1;
    end
  end
`else
  assign wdt_trip = 1'b0;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: tile expectations queued at start,
// checked by a monitor when done pulses.
module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] n_act = '0;
  logic       l0_empty = 1'b0;
  logic       l0_rd;
  logic [1:0] inst;
  logic       ld_done = 1'b1;
  logic       ofifo_valid = 1'b1;
  logic       ofifo_rd;
  logic       busy;
  logic       done;
  logic [5:0] out_cnt;
  logic       err;

  mac_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .n_act(n_act),
    .l0_empty(l0_empty), .l0_rd(l0_rd), .inst(inst),
    .ld_done(ld_done), .ofifo_valid(ofifo_valid),
    .ofifo_rd(ofifo_rd), .busy(busy), .done(done),
    .out_cnt(out_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int lat;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0;
  int t0 = 0;
  int n_ld = 0, n_ex = 0, n_rd = 0, bad = 0;
  int ndone = 0;

  task automatic chk(string name, int act, int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  always @(posedge clk) cyc++;

  // monitor: accumulates per-tile activity, scores it on done
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      n_ld = 0; n_ex = 0; n_rd = 0; bad = 0;
    end else begin
      if (start && !busy) t0 = cyc;
      if (l0_rd != (inst != 2'b00) || inst == 2'b11) bad++;
      if (inst == 2'b01 && l0_rd) n_ld++;
      if (inst == 2'b10 && l0_rd) n_ex++;
      if (ofifo_rd) n_rd++;
      if (done) begin
        ndone++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_cnt", int'(out_cnt), e.n);
          chk("latency", cyc - t0 + 1, e.lat);
          chk("load_issues", n_ld, 8);
          chk("exec_issues", n_ex, e.n);
          chk("ofifo_pops", n_rd, e.n);
          chk("inst_l0rd_pairing", bad, 0);
          chk("err_at_done", int'(err), 0);
        end
        n_ld = 0; n_ex = 0; n_rd = 0; bad = 0;
      end
    end
  end

  task automatic wait_done(int lim);
    int d0 = ndone;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (ndone != d0) break;
    end
    chk("tile_done", ndone - d0, 1);
  endtask

  task automatic run_tile(int n, int lat);
    sb.push_back('{n, lat});
    @(posedge clk); #1;
    start = 1'b1;
    n_act = 6'(n);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
  endtask

  initial begin
    int bsy;
    int d0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", int'(inst), 0);
    chk("rst_l0_rd", int'(l0_rd), 0);
    chk("rst_ofifo_rd", int'(ofifo_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_cnt", int'(out_cnt), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: abort mid-EXEC after three of five issues
    start = 1'b1;
    n_act = 6'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (n_ex == 3) break;
    end
    chk("abort_exec_seen", n_ex, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_inst", int'(inst), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_cnt", int'(out_cnt), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_tile(5, 28);

    // 2: nominal tile
    run_tile(4, 26);

    // 3: L0 empty for three cycles after the second load
    sb.push_back('{4, 29});
    @(posedge clk); #1;
    start = 1'b1;
    n_act = 6'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("gap_loads_before", n_ld, 2);
    l0_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_inst", int'(inst), 0);
      chk("gap_l0_rd", int'(l0_rd), 0);
    end
    @(posedge clk); #1;
    l0_empty = 1'b0;
    wait_done(400);

    // 4: no activations
    run_tile(0, 18);

    // boundary: largest activation count
    run_tile(63, 144);

    // 5: start held through the whole tile
    sb.push_back('{3, 24});
    d0 = ndone;
    @(posedge clk); #1;
    start = 1'b1;
    n_act = 6'd3;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (ndone != d0) break;
    end
    start = 1'b0;
    bsy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) bsy++;
    end
    chk("held_start_one_tile", ndone - d0, 1);
    chk("held_start_idle_after", bsy, 0);

`ifdef MAC_SEQ_WDT_EN
    // 6: watchdog abort while weights never settle
    ld_done = 1'b0;
    d0 = ndone;
    @(posedge clk); #1;
    start = 1'b1;
    n_act = 6'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk); #1;
      if (err) break;
    end
    chk("wdt_err", int'(err), 1);
    chk("wdt_busy", int'(busy), 0);
    chk("wdt_no_done", ndone - d0, 0);
    ld_done = 1'b1;
    run_tile(2, 22);
    chk("wdt_err_cleared", int'(err), 0);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
